regfile_scalar_mt: RTL
======================

# regfile_scalar_mt

Multi-thread scalar register file for the compute unit. It holds NTHREADS independent contexts of NREGS×XLEN registers, with NREAD combinational read ports and two write ports: ALU writeback and load return. A per-register scoreboard tracks outstanding loads, and a sweep FSM zeroes storage after reset and on per-thread clear requests. It replaces the single-context scalar register file in the issue/writeback path.

## Interface
- XLEN, 32, register width
- NREGS, 32, registers per thread (power of 2, ≥2); AW = $clog2(NREGS)
- NTHREADS, 4, thread contexts (power of 2, ≥1); TW = max(1,$clog2(NTHREADS))
- NREAD, 2, read ports
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- rd_tid  in  TW  thread for all read ports
- raddr  in  NREAD*AW  read addresses; port p at [p*AW +: AW]
- rdata  out  NREAD*XLEN  read data, combinational
- rbusy  out  NREAD  scoreboard pending bit per read port, combinational
- w0_en / w0_tid / w0_addr / w0_data  in  1/TW/AW/XLEN  ALU writeback
- w1_en / w1_tid / w1_addr / w1_data  in  1/TW/AW/XLEN  load return; clears the scoreboard bit
- sb_set_en / sb_set_tid / sb_set_addr  in  1/TW/AW  marks a register pending (load issue)
- clr_req / clr_tid  in  1/TW  request zeroing of one thread context
- clr_busy  out  1  sweep FSM not IDLE
- clr_done  out  1  one-cycle pulse when a requested clear completes
- ready  out  1  initial sweep finished

## Operation
- Storage has no reset; it is zeroed by the sweep FSM. Scoreboard bits, FSM state and counters are asynchronously reset.
- FSM states: INIT → IDLE ↔ CLEAR.
- INIT (entered on reset): writes one zero entry per cycle. The index walks reg 0..NREGS-1 for tid 0, then tid 1, and so on. It lasts NTHREADS*NREGS cycles, then enters IDLE.
- In INIT, all writes and sb_set are ignored, rdata=0, rbusy=0, ready=0.
- IDLE: clr_req=1 latches clr_tid, clears all NREGS scoreboard bits of that thread, and enters CLEAR at the next edge.
- clr_req while clr_busy=1 is ignored and not queued.
- CLEAR: zeroes reg 0..NREGS-1 of the latched thread, one per cycle, for exactly NREGS cycles, then returns to IDLE.
- During CLEAR, for the latched thread:
  - w0/w1/sb_set are dropped.
  - Reads with rd_tid equal to the latched thread return 0 with rbusy=0.
  - Other threads operate normally.
- Register 0 of every thread: reads return 0, writes and sb_set are ignored, and its scoreboard bit is always 0.
- Write priority on the same tid/addr in the same cycle: w1 wins; the array takes w1_data.
- Read bypass: a read matching an enabled, non-dropped write this cycle (same tid/addr, addr≠0) returns that write's data. If both writes match, it returns w1_data.
- Scoreboard update per cycle:
  - sb_set sets the bit.
  - A non-dropped w1 clears it.
  - If both target the same bit, set wins.
  - w0 does not affect the scoreboard.
- rbusy[p] = stored bit of (rd_tid, raddr[p]), forced to 0 when a non-dropped w1 to that reg occurs this cycle without a same-reg sb_set.

## Timing
- Reset values: ready=0, clr_busy=1, clr_done=0, rbusy=0, rdata=0, all scoreboard bits 0, FSM in INIT with index 0.
- ready rises at reset deassertion plus NTHREADS*NREGS cycles. No clr_done pulse follows INIT.
- clr_req sampled at edge E:
  - clr_busy=1 from E through E+NREGS.
  - FSM is in IDLE at edge E+NREGS+1; clr_done=1 for that one cycle only.
  - A new clr_req in that cycle is accepted.
- Writes take effect at the clock edge; a read in the same cycle sees them through the bypass.
- Reset asserted mid-CLEAR or mid-INIT: immediately INIT, scoreboard cleared, clr_done=0, and the full sweep restarts.
- Address and tid arithmetic is unsigned and in-range by construction; no wrap logic beyond the counter width.

## Test plan
- Reset with defaults: ready=0 for 128 cycles, then 1. Read of any tid/reg returns 0. clr_busy falls at the same edge ready rises.
- w0 tid1 r5=0xDEADBEEF, then read tid1 r5 → 0xDEADBEEF. Read tid2 r5 → 0. Write r0 → read r0 = 0.
- Same cycle: w0 and w1 to tid0 r7 with 0x11/0x22 → same-cycle read 0x22, next-cycle read 0x22.
- sb_set tid3 r9 → rbusy=1 next cycle. Then w1 tid3 r9=0x5 → rbusy=0 in the same cycle, rdata=0x5. Same-cycle sb_set plus w1 on r9 → rbusy stays 1.
- clr_req tid2 after filling r1..r31: clr_busy for 32 cycles, clr_done pulses once. tid2 reads 0 throughout; tid0 data is intact. A w0 to tid2 during CLEAR is dropped. A second clr_req during CLEAR is ignored.
- Assert rst_n low at cycle 10 of a CLEAR: INIT restarts, scoreboard is cleared, ready=0 for 128 cycles.

Source files
------------

// File: rtl/regfile_scalar_mt.sv
// Multi-thread scalar register file: NTHREADS contexts, NREAD combinational reads, ALU and load-return write ports, load scoreboard.
// Latency: reads are combinational with same-cycle write bypass; writes land at the next clk edge.
// Backpressure: none; writes/sb_set are dropped during INIT and for the thread being cleared, and clr_req is ignored while clr_busy.
module regfile_scalar_mt #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NTHREADS = 4,
    parameter int NREAD    = 2,
    localparam int AW      = $clog2(NREGS),
    localparam int TW      = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [TW-1:0]         rd_tid,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    output logic [NREAD-1:0]      rbusy,

    input  logic                  w0_en,
    input  logic [TW-1:0]         w0_tid,
    input  logic [AW-1:0]         w0_addr,
    input  logic [XLEN-1:0]       w0_data,

    input  logic                  w1_en,
    input  logic [TW-1:0]         w1_tid,
    input  logic [AW-1:0]         w1_addr,
    input  logic [XLEN-1:0]       w1_data,

    input  logic                  sb_set_en,
    input  logic [TW-1:0]         sb_set_tid,
    input  logic [AW-1:0]         sb_set_addr,

    input  logic                  clr_req,
    input  logic [TW-1:0]         clr_tid,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  ready
);

    // Flat storage index is {tid, addr}, so thread t occupies entries t*NREGS .. t*NREGS+NREGS-1.
    localparam int IW    = TW + AW;
    localparam int DEPTH = NTHREADS * NREGS;
    localparam logic [IW-1:0] LAST_INIT = IW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_REG  = AW'(NREGS - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   ctid_q, ctid_d;
    logic            done_q, done_d;
    logic            clr_accept;

    logic [XLEN-1:0] mem [DEPTH];
    logic [DEPTH-1:0] sb_q, sb_d;

    logic            in_init, in_clear;
    logic            w0_ok, w1_ok, sb_ok;
    logic [IW-1:0]   w0_idx, w1_idx, sb_idx;
    logic            sweep_en;
    logic [IW-1:0]   sweep_idx;

    function automatic logic [IW-1:0] flat(input logic [TW-1:0] tid, input logic [AW-1:0] addr);
        return {tid, addr};
    endfunction

    assign in_init  = (state_q == ST_INIT);
    assign in_clear = (state_q == ST_CLEAR);

    // A write is live unless we are sweeping everything, its thread is being cleared, or it targets r0.
    assign w0_ok = w0_en && !in_init && !(in_clear && (w0_tid == ctid_q)) && (w0_addr != '0);
    assign w1_ok = w1_en && !in_init && !(in_clear && (w1_tid == ctid_q)) && (w1_addr != '0);
    assign sb_ok = sb_set_en && !in_init && !(in_clear && (sb_set_tid == ctid_q)) && (sb_set_addr != '0);

    assign w0_idx = flat(w0_tid, w0_addr);
    assign w1_idx = flat(w1_tid, w1_addr);
    assign sb_idx = flat(sb_set_tid, sb_set_addr);

    // INIT walks the whole flat array; CLEAR walks only the latched thread.
    assign sweep_en  = in_init || in_clear;
    assign sweep_idx = in_init ? idx_q : flat(ctid_q, idx_q[AW-1:0]);

    // Sweep sequencing: next state, counter, latched thread and completion pulse.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ctid_d     = ctid_q;
        done_d     = 1'b0;
        clr_accept = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (idx_q == LAST_INIT) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    clr_accept = 1'b1;
                    ctid_d     = clr_tid;
                    idx_d      = '0;
                    state_d    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (idx_q[AW-1:0] == LAST_REG) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = '0;
            end
        endcase
    end

    // Scoreboard next value: load return clears, load issue sets (set wins), clear request wipes the thread.
    always_comb begin
        sb_d = sb_q;
        if (w1_ok) begin
            sb_d[w1_idx] = 1'b0;
        end
        if (sb_ok) begin
            sb_d[sb_idx] = 1'b1;
        end
        if (clr_accept) begin
            for (int r = 0; r < NREGS; r++) begin
                sb_d[flat(clr_tid, AW'(r))] = 1'b0;
            end
        end
    end

    // Control state and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            ctid_q  <= '0;
            done_q  <= 1'b0;
            sb_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ctid_q  <= ctid_d;
            done_q  <= done_d;
            sb_q    <= sb_d;
        end
    end

    // Register array: sweep zeroing, then w0, then w1 so load return wins on a same-entry collision.
    // The sweep never collides with a live write since writes to the swept thread are dropped.
    always_ff @(posedge clk) begin
        if (sweep_en) begin
            mem[sweep_idx] <= '0;
        end
        if (w0_ok) begin
            mem[w0_idx] <= w0_data;
        end
        if (w1_ok) begin
            mem[w1_idx] <= w1_data;
        end
    end

    // Read ports with write bypass; masked reads (INIT, thread under clear, r0) return zero and not-busy.
    always_comb begin
        logic [AW-1:0]   ra;
        logic [IW-1:0]   ri;
        logic            masked;
        logic            h0, h1, hs;
        rdata  = '0;
        rbusy  = '0;
        ra     = '0;
        ri     = '0;
        masked = 1'b1;
        h0     = 1'b0;
        h1     = 1'b0;
        hs     = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            ra     = raddr[p*AW +: AW];
            ri     = flat(rd_tid, ra);
            masked = in_init || (in_clear && (rd_tid == ctid_q)) || (ra == '0);
            h0     = w0_ok && (w0_idx == ri);
            h1     = w1_ok && (w1_idx == ri);
            hs     = sb_ok && (sb_idx == ri);
            if (!masked) begin
                if (h1) begin
                    rdata[p*XLEN +: XLEN] = w1_data;
                end else if (h0) begin
                    rdata[p*XLEN +: XLEN] = w0_data;
                end else begin
                    rdata[p*XLEN +: XLEN] = mem[ri];
                end
                rbusy[p] = sb_q[ri] && !(h1 && !hs);
            end
        end
    end

    assign ready    = (state_q != ST_INIT);
    assign clr_busy = (state_q != ST_IDLE);
    assign clr_done = done_q;

endmodule
